// File: rtl/mult_share_sched_if.sv
// Operand request / product response bundle between N requesters and the shared-multiplier scheduler.
interface mult_share_sched_if #(parameter int N = 4) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_x;
  logic [4*N-1:0] req_y;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [7:0]     rsp_prod;
  logic [IDW-1:0] rsp_id;
  logic           busy;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_prod, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_prod, rsp_id, busy
  );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin scheduler time-sharing one 4x4 multiplier; operands registered in S1, product in S2 (2-edge latency).
// A stalled response port holds S2, then S1 fills, after which every req_ready stays low until the stall clears.
module mult_share_sched #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mult_share_sched_if.slave io_bus
);
  localparam int SW = IDW + 2;

  logic           r_s1_valid;
  logic [3:0]     r_op_x;
  logic [3:0]     r_op_y;
  logic [IDW-1:0] r_op_id;
  logic [IDW-1:0] r_ptr;
  logic           r_rsp_valid;
  logic [7:0]     r_rsp_prod;
  logic [IDW-1:0] r_rsp_id;

  logic           w_s2_load;
  logic           w_s1_free;
  logic           w_any;
  logic           w_acc;
  logic [SW-1:0]  w_base;
  logic [SW-1:0]  w_off;
  logic [SW-1:0]  w_sum;
  logic [N-1:0]   w_rot;
  logic [IDW-1:0] w_gnt;
  logic [3:0]     w_x;
  logic [3:0]     w_y;
  logic [7:0]     w_mul;

  assign w_s2_load = r_s1_valid & (~r_rsp_valid | io_bus.rsp_ready);
  assign w_s1_free = ~r_s1_valid | w_s2_load;

  // Rotate requests so bit 0 is requester ptr+1; w_base ranges 1..N, so the rotation never overflows.
  assign w_base = SW'(r_ptr) + SW'(1);
  assign w_rot  = (io_bus.req_valid >> w_base) | (io_bus.req_valid << (SW'(N) - w_base));

  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_any = 1'b1;
        w_off = SW'(j);
      end
    end
  end

  assign w_sum = w_base + w_off;
  assign w_gnt = (w_sum >= SW'(N)) ? IDW'(w_sum - SW'(N)) : IDW'(w_sum);
  assign w_acc = w_any & w_s1_free & ~i_rst;

  assign io_bus.req_ready = w_acc ? (N'(1) << w_gnt) : '0;

  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_x = io_bus.req_x[4*i +: 4];
        w_y = io_bus.req_y[4*i +: 4];
      end
    end
  end

  main u_mul (
    .x (r_op_x),
    .y (r_op_y),
    .o (w_mul)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid  <= 1'b0;
      r_op_x      <= '0;
      r_op_y      <= '0;
      r_op_id     <= '0;
      r_ptr       <= IDW'(N - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_prod  <= '0;
      r_rsp_id    <= '0;
    end else begin
      if (w_acc) begin
        r_s1_valid <= 1'b1;
        r_op_x     <= w_x;
        r_op_y     <= w_y;
        r_op_id    <= w_gnt;
        r_ptr      <= w_gnt;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_prod  <= w_mul;
        r_rsp_id    <= r_op_id;
      end else if (io_bus.rsp_ready & r_rsp_valid) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_prod  = r_rsp_prod;
  assign io_bus.rsp_id    = r_rsp_id;
  assign io_bus.busy      = r_s1_valid | r_rsp_valid;
endmodule

// Shared unsigned 4x4 -> 8 combinational multiplier.
module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);
  assign o = {4'b0000, x} * {4'b0000, y};
endmodule
